shift_register_4_ctrl: RTL
==========================

# shift_register_4_ctrl

Command sequencer for the 4-bit universal shift register (`shift_register_4_beh`). It accepts one command at a time over a start/ready handshake: parallel load, shift right, shift left, or rotate right by N. It drives the register's mode selects, parallel input and serial inputs cycle by cycle, and signals completion with a one-cycle `done` pulse. It replaces free-running s1/s0 stimulus with controlled, countable operations.

## Interface
- `CNT_W`, default 4: width of the shift count; the maximum count is 2^CNT_W−1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `clear`  in  1  asynchronous, active-low reset; the same net also drives the register's `clear`
- `start`  in  1  command request; accepted only while `ready`=1
- `op`  in  2  command: 00 LOAD, 01 SHR, 10 SHL, 11 ROTR
- `count`  in  CNT_W  number of shift cycles; ignored for LOAD
- `din`  in  4  parallel data for LOAD
- `ser_in`  in  1  serial source bit; consumed on every SHR/SHL shift edge
- `abort`  in  1  terminates a shift command early
- `a_par`  in  4  register output, fed back from the register
- `ready`  out  1  controller is idle and will accept `start`
- `busy`  out  1  equals NOT `ready`
- `done`  out  1  one-cycle pulse at the end of every accepted command
- `aborted`  out  1  valid only while `done`=1; 1 = command was cut short
- `ser_req`  out  1  high in every cycle whose closing edge shifts
- `ser_out`  out  1  bit leaving the register: `a_par[0]` for SHR/ROTR, `a_par[3]` for SHL, 0 otherwise
- `s1`, `s0`  out  1 each  register mode: 00 hold, 01 shift right, 10 shift left, 11 load
- `i_par`  out  4  parallel data to the register
- `msb_in`  out  1  enters `a[3]` on a right shift: `ser_in` for SHR, `a_par[0]` for ROTR, else 0
- `lsb_in`  out  1  enters `a[0]` on a left shift: `ser_in` for SHL, else 0

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- Reset values: state IDLE, `s1 s0`=00, `i_par`=0000, internal op/count registers 0, `done`=0, `aborted`=0, `ready`=1, `busy`=0, `ser_req`=0.
- IDLE: `ready`=1 and `s`=00.
  - `start` at an edge latches `op`, `count` and `din` (into `i_par`).
  - Next state: LOAD for op 00; SHIFT for a shift op with count≥1; DONE for a shift op with count=0.
- LOAD: `s`=11 for exactly one cycle, so the register loads `i_par` at the closing edge. Next state DONE.
- SHIFT: `s`=01 for SHR/ROTR and 10 for SHL; `ser_req`=1.
  - The remaining-count register decrements at each edge.
  - The state moves to DONE at the edge where remaining reaches 0.
- DONE: `s`=00, `done`=1, `ready`=0 for one cycle, then IDLE.
- `msb_in`, `lsb_in` and `ser_out` are combinational from the latched op, `ser_in` and `a_par`. ROTR is therefore a true rotate.
- Abort: `abort`=1 during a SHIFT cycle.
  - That cycle's shift still occurs; the state then goes to DONE.
  - `aborted`=1 unless that cycle was already the final shift.
  - `abort` is ignored in every other state.
- `start` is ignored while `ready`=0, including in the DONE cycle.
- `op`, `count` and `din` are don't-care except at the accepting edge.
- Asserting `clear` mid-command forces IDLE and the reset values immediately; the register is cleared as well.

## Timing
- E0 = the accepting edge.
- LOAD: `s`=11 in cycle E0–E1; `a_par`=`din` after E1; `done` high during E1–E2; `ready` again after E2.
- Shift with count N≥1:
  - Shifts occur at E1..EN.
  - `done` is high during EN–EN+1.
  - Total latency from accept to `ready` is N+2 edges.
- Shift with count 0: no shift occurs; `done` is high during E0–E1; `ready` again after E1.
- Back-to-back: `start` held high is accepted at the first edge where `ready`=1, giving one idle cycle between commands.

## Test plan
- Reset, then LOAD `din`=1010 → `s`=11 for one cycle; `a_par`=1010 after E1; one `done` pulse with `aborted`=0; `ready`=1 after E2.
- From 0000, SHR count 3 with `ser_in`=1,1,0 on E1..E3 → `a_par`=1000, 1100, 0110; `ser_req` high for exactly 3 cycles; `done` during E3–E4.
- LOAD 1010 then ROTR count 1 → 0101; ROTR count 4 from 1010 → 1010; SHL count 2 from 0011 with `ser_in`=1,0 → 0111 then 1110; `ser_out` shows 0 then 0.
- SHL count 0 → `done` in the cycle after E0; `a_par` unchanged; `ser_req` never high. `start` pulsed during a running SHR count 5 → ignored; exactly 5 shifts occur.
- SHR count 5 with `abort` during the 2nd SHIFT cycle → exactly 2 shifts, then `done`=1 with `aborted`=1. `abort` during the 5th cycle → 5 shifts and `aborted`=0.
- `clear` low during the 3rd cycle of SHR count 6 → `s`=00, `ready`=1, `done`=0 and `a_par`=0000 immediately; a subsequent LOAD 0110 completes normally.

Source files
------------

// File: rtl/shift_register_4_ctrl.sv
// shift_register_4_ctrl: start/ready command sequencer driving a 4-bit universal shift register
module shift_register_4_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] count,
  input  logic [3:0]       din,
  input  logic             ser_in,
  input  logic             abort,
  input  logic [3:0]       a_par,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             ser_req,
  output logic             ser_out,
  output logic             s1,
  output logic             s0,
  output logic [3:0]       i_par,
  output logic             msb_in,
  output logic             lsb_in
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  localparam logic [1:0] OP_LOAD = 2'd0, OP_SHR = 2'd1, OP_SHL = 2'd2, OP_ROTR = 2'd3;
  state_t           r_state;
  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_s;
  logic [3:0]       r_par;
  logic             r_ready;
  logic             r_done;
  logic             r_aborted;
  logic             r_ser_req;
  logic             w_last;
  assign w_last = r_cnt == CNT_W'(1);
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state   <= IDLE;
      r_op      <= OP_LOAD;
      r_cnt     <= '0;
      r_s       <= 2'b00;
      r_par     <= 4'b0000;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_ser_req <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_op    <= op;
          r_cnt   <= count;
          r_par   <= din;
          r_ready <= 1'b0;
          if (op == OP_LOAD) begin
            r_state <= LOAD;
            r_s     <= 2'b11;
          end else if (count == '0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state   <= SHIFT;
            r_s       <= op == OP_SHL ? 2'b10 : 2'b01;
            r_ser_req <= 1'b1;
          end
        end
        LOAD: begin
          r_state <= DONE;
          r_s     <= 2'b00;
          r_done  <= 1'b1;
        end
        SHIFT: begin
          r_cnt <= r_cnt - 1'b1;
          // the abort cycle still shifts; it only counts as cut short if shifts remain
          if (w_last || abort) begin
            r_state   <= DONE;
            r_s       <= 2'b00;
            r_ser_req <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= abort && !w_last;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_done    <= 1'b0;
          r_aborted <= 1'b0;
          r_ready   <= 1'b1;
        end
      endcase
    end
  end
  assign ready   = r_ready;
  assign busy    = ~r_ready;
  assign done    = r_done;
  assign aborted = r_aborted;
  assign ser_req = r_ser_req;
  assign s1      = r_s[1];
  assign s0      = r_s[0];
  assign i_par   = r_par;
  assign msb_in  = r_op == OP_SHR ? ser_in : r_op == OP_ROTR ? a_par[0] : 1'b0;
  assign lsb_in  = r_op == OP_SHL && ser_in;
  assign ser_out = r_op == OP_SHL ? a_par[3] : (r_op == OP_SHR || r_op == OP_ROTR) ? a_par[0] : 1'b0;
endmodule
